// File: rtl/apb_cmd_queue.sv
// First-word-fall-through command FIFO feeding the APB bridge request port.
// Optional registered almost_full output enabled by defining APB_CMDQ_AFULL_EN.
module apb_cmd_queue #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH/8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH-1
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_write,
    input  logic [ADDR_WIDTH-1:0]     s_addr,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [STRB_WIDTH-1:0]     s_strb,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_write,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [STRB_WIDTH-1:0]     m_strb,
`ifdef APB_CMDQ_AFULL_EN
    output logic                      almost_full,
`endif
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;

    logic                  mem_write [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_wdata [DEPTH];
    logic [STRB_WIDTH-1:0] mem_strb  [DEPTH];

    assign s_ready = presetn & (count != FULL_CNT) & ~flush;
    assign m_valid = (count != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Payload is zeroed while empty so the bridge never sees stale entries.
    assign m_write = m_valid ? mem_write[rd_ptr] : 1'b0;
    assign m_addr  = m_valid ? mem_addr[rd_ptr]  : '0;
    assign m_wdata = m_valid ? mem_wdata[rd_ptr] : '0;
    assign m_strb  = m_valid ? mem_strb[rd_ptr]  : '0;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // Storage is data only; validity is carried entirely by count.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_write[wr_ptr] <= s_write;
            mem_addr[wr_ptr]  <= s_addr;
            mem_wdata[wr_ptr] <= s_wdata;
            mem_strb[wr_ptr]  <= s_write ? s_strb : '0;
        end
    end

`ifdef APB_CMDQ_AFULL_EN
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            almost_full <= 1'b0;
        end else if (flush) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= AFULL_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Self-checking bench for apb_cmd_queue: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic with flush and reset.
module tb_apb_cmd_queue;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 4;
    localparam int THR   = DEPTH-1;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_write = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_wdata = '0;
    logic [SW-1:0] s_strb = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [2:0]    count;
`ifdef APB_CMDQ_AFULL_EN
    logic          almost_full;
`endif

    apb_cmd_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .DEPTH(DEPTH),
                    .AFULL_THRESH(THR)) dut (
        .pclk(pclk), .presetn(presetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_write(s_write), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_strb(s_strb),
        .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_strb(m_strb),
`ifdef APB_CMDQ_AFULL_EN
        .almost_full(almost_full),
`endif
        .count(count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } cmd_t;

    cmd_t          q[$];
    logic [AW-1:0] popped[$];
    logic          exp_af = 1'b0;
    int            checks = 0;
    int            errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a plain queue of commands, updated on each rising edge.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            q.delete();
            exp_af = 1'b0;
        end else if (flush) begin
            q.delete();
            exp_af = 1'b0;
        end else begin
            bit do_push, do_pop;
            cmd_t c;
            do_push = s_valid && (q.size() != DEPTH);
            do_pop  = (q.size() != 0) && m_ready;
            if (do_pop) begin
                popped.push_back(q[0].a);
                void'(q.pop_front());
            end
            if (do_push) begin
                c.w = s_write; c.a = s_addr; c.d = s_wdata;
                c.s = s_write ? s_strb : '0;
                q.push_back(c);
            end
            exp_af = (q.size() >= THR);
        end
    end

    // Compare process: every falling edge.
    always @(negedge pclk) begin
        cmd_t h;
        bit   e_valid;
        e_valid = presetn && (q.size() != 0);
        if (e_valid) h = q[0];
        else begin h.w = 1'b0; h.a = '0; h.d = '0; h.s = '0; end
        chk("count",   64'(count),   presetn ? 64'(q.size()) : 64'd0);
        chk("m_valid", 64'(m_valid), 64'(e_valid));
        chk("s_ready", 64'(s_ready), 64'(presetn && q.size() != DEPTH && !flush));
        chk("m_write", 64'(m_write), 64'(h.w));
        chk("m_addr",  64'(m_addr),  64'(h.a));
        chk("m_wdata", 64'(m_wdata), 64'(h.d));
        chk("m_strb",  64'(m_strb),  64'(h.s));
`ifdef APB_CMDQ_AFULL_EN
        chk("almost_full", 64'(almost_full), 64'(presetn && exp_af));
`endif
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input logic mr);
        s_valid = v; s_write = w; s_addr = a; s_wdata = d; s_strb = s; m_ready = mr;
    endtask

    initial begin
        int k;
        int budget;
        logic acc;

        // Reset held for two cycles.
        tick(); tick();
        chk("rst_count", 64'(count), 0);
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_m_valid", 64'(m_valid), 0);
        presetn = 1'b1;
        #1;
        chk("rel_s_ready", 64'(s_ready), 1);

        // Single write, held then consumed.
        drive(1, 1, 32'h10, 32'hA5A5_A5A5, 4'hF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("w_m_valid", 64'(m_valid), 1);
        chk("w_m_addr", 64'(m_addr), 64'h10);
        chk("w_m_wdata", 64'(m_wdata), 64'hA5A5_A5A5);
        chk("w_m_strb", 64'(m_strb), 64'hF);
        chk("w_count", 64'(count), 1);
        tick(); tick(); tick();
        chk("w_hold_addr", 64'(m_addr), 64'h10);
        chk("w_hold_count", 64'(count), 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("w_pop_count", 64'(count), 0);

        // Read: strobes stored as zero.
        drive(1, 0, 32'h20, 32'h1234_5678, 4'hF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("r_m_write", 64'(m_write), 0);
        chk("r_m_strb", 64'(m_strb), 0);
        chk("r_m_addr", 64'(m_addr), 64'h20);
        tick();
        m_ready = 1'b0;

        // Fill to full, then stream 6 more with m_ready high.
        popped.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, AW'(i), DW'(32'h100 + i), 4'h3, 0);
            tick();
        end
        chk("full_count", 64'(count), 4);
        chk("full_s_ready", 64'(s_ready), 0);
        k = DEPTH;
        budget = 0;
        drive(1, 1, AW'(k), DW'(32'h100 + k), 4'h3, 1);
        tick();
        chk("full_pop_count", 64'(count), 3);
        chk("full_pop_s_ready", 64'(s_ready), 1);
        while (k < 10 && budget < 50) begin
            drive(1, 1, AW'(k), DW'(32'h100 + k), 4'h3, 1);
            acc = s_ready;
            tick();
            if (acc) k++;
            budget++;
        end
        chk("fill_accepted", 64'(k), 10);
        s_valid = 1'b0;
        budget = 0;
        while (count != 0 && budget < 20) begin tick(); budget++; end
        m_ready = 1'b0;
        chk("drain_len", 64'(popped.size()), 10);
        for (int i = 0; i < 10; i++)
            chk("order", (i < popped.size()) ? 64'(popped[i]) : 64'hDEAD, 64'(i));

        // Simultaneous push and pop at count 2.
        drive(1, 1, 32'h40, 32'h40, 4'h1, 0); tick();
        drive(1, 1, 32'h41, 32'h41, 4'h1, 0); tick();
        drive(1, 1, 32'h42, 32'h42, 4'h1, 1); tick();
        chk("pp_count", 64'(count), 2);
        chk("pp_head", 64'(m_addr), 64'h41);

        // Flush at count 3 with concurrent push and pop.
        drive(1, 1, 32'h43, 32'h43, 4'h1, 0); tick();
        chk("pre_flush_count", 64'(count), 3);
`ifdef APB_CMDQ_AFULL_EN
        chk("pre_flush_af", 64'(almost_full), 1);
`endif
        drive(1, 1, 32'h44, 32'h44, 4'h1, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_count", 64'(count), 0);
        chk("flush_m_valid", 64'(m_valid), 0);
`ifdef APB_CMDQ_AFULL_EN
        chk("flush_af", 64'(almost_full), 0);
`endif

        // Randomized traffic with occasional flush and asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
                  4'($urandom), $urandom_range(0, 2) == 0 ? 1'b1 : 1'b0);
            flush = ($urandom_range(0, 40) == 0);
            if (presetn && $urandom_range(0, 300) == 0) presetn = 1'b0;
            else if (!presetn && $urandom_range(0, 2) == 0) presetn = 1'b1;
            tick();
        end
        presetn = 1'b1;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
